// File: rtl/eth_phy_10g_rx_gearbox_if.sv
// Bus bundle between the raw transceiver word source and the 32:66 receive gearbox.
// The master drives raw words and bitslip requests; the slave returns assembled 66-bit blocks.
interface eth_phy_10g_rx_gearbox_if #(
    parameter int IN_WIDTH   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2
);
    logic [IN_WIDTH-1:0]   in_data;
    logic                  in_valid;
    logic                  bitslip;
    logic [DATA_WIDTH-1:0] out_data;
    logic [HDR_WIDTH-1:0]  out_hdr;
    logic                  out_valid;

    modport master (
        output in_data, in_valid, bitslip,
        input  out_data, out_hdr, out_valid
    );

    modport slave (
        input  in_data, in_valid, bitslip,
        output out_data, out_hdr, out_valid
    );
endinterface

// File: rtl/eth_phy_10g_rx_gearbox.sv
// Receive 32:66 gearbox: packs raw transceiver words into sync-header + payload blocks,
// dropping one received bit per pending bitslip request to walk block alignment.
module eth_phy_10g_rx_gearbox #(
    parameter int IN_WIDTH   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    eth_phy_10g_rx_gearbox_if.slave  rx
);
    localparam int BLK_W = DATA_WIDTH + HDR_WIDTH;
    localparam int BUF_W = BLK_W + IN_WIDTH;
    localparam int CNT_W = $clog2(BUF_W);
    localparam logic [CNT_W-1:0] BLK_CNT = CNT_W'(BLK_W);
    localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_WIDTH);

    logic [BUF_W-1:0] bits;
    logic [BUF_W-1:0] bits_emit;
    logic [BUF_W-1:0] bits_slip;
    logic [BUF_W-1:0] bits_next;
    logic [BUF_W-1:0] keep_mask;
    logic [BUF_W-1:0] word_ext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_emit;
    logic [CNT_W-1:0] cnt_slip;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       slip_pending;
    logic [1:0]       slip_next;
    logic             emit;
    logic             slip;

    // Emit, then slip, then append, all against the same cycle's buffer; bit 0 is the oldest bit.
    always_comb begin
        emit      = (cnt >= BLK_CNT);
        bits_emit = emit ? (bits >> BLK_W) : bits;
        cnt_emit  = emit ? (cnt - BLK_CNT) : cnt;

        slip      = (slip_pending != 2'd0) && (cnt_emit != '0);
        bits_slip = slip ? (bits_emit >> 1) : bits_emit;
        cnt_slip  = slip ? (cnt_emit - 1'b1) : cnt_emit;

        keep_mask = (BUF_W'(1) << cnt_slip) - BUF_W'(1);
        word_ext  = BUF_W'(rx.in_data);
        bits_next = bits_slip;
        cnt_next  = cnt_slip;
        if (rx.in_valid) begin
            bits_next = (bits_slip & keep_mask) | (word_ext << cnt_slip);
            cnt_next  = cnt_slip + IN_CNT;
        end

        // A request arriving while one is consumed leaves the count unchanged.
        slip_next = slip_pending;
        if (rx.bitslip && !slip && slip_pending != 2'd3) begin
            slip_next = slip_pending + 2'd1;
        end else if (!rx.bitslip && slip) begin
            slip_next = slip_pending - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits         <= '0;
            cnt          <= '0;
            slip_pending <= 2'd0;
            rx.out_data  <= '0;
            rx.out_hdr   <= '0;
            rx.out_valid <= 1'b0;
        end else begin
            bits         <= bits_next;
            cnt          <= cnt_next;
            slip_pending <= slip_next;
            rx.out_valid <= emit;
            if (emit) begin
                rx.out_hdr  <= bits[HDR_WIDTH-1:0];
                rx.out_data <= bits[BLK_W-1:HDR_WIDTH];
            end
        end
    end
endmodule
